// File: rtl/prior_lock_arbiter.sv
// prior_lock_arbiter: packet arbiter that selects one requester in fixed-priority
// or round-robin mode. Once the head flit of a multi-flit packet is accepted, it
// holds the grant on that requester until the tail flit is accepted.
// Grant is combinational from the request inputs. Lock state and the RR pointer
// are registered.
module prior_lock_arbiter #(
    parameter int N_OF_INPUTS = 2,
    parameter int RR_MODE     = 1,
    parameter int IDX_W       = (N_OF_INPUTS > 1) ? $clog2(N_OF_INPUTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_OF_INPUTS-1:0] req_i,
    input  logic [N_OF_INPUTS-1:0] tail_i,
    input  logic                   ready_i,
    output logic [N_OF_INPUTS-1:0] grant_o,
    output logic [IDX_W-1:0]       grant_idx_o,
    output logic                   valid_o,
    output logic                   locked_o
);

    localparam logic [IDX_W:0]   N_EXT = N_OF_INPUTS[IDX_W:0];
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_OF_INPUTS - 1);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                   state, state_nx;
    logic [IDX_W-1:0]         lock_idx, lock_nx;
    logic [IDX_W-1:0]         rr_ptr, ptr_nx;

    logic [IDX_W-1:0]         scan_base;
    logic [N_OF_INPUTS-1:0]   req_rot;
    logic [IDX_W-1:0]         win_off;
    logic [IDX_W:0]           win_sum;
    logic [IDX_W-1:0]         win_idx;
    logic                     win_any;
    logic                     win_tail;
    logic                     own_req;
    logic                     own_tail;
    logic                     g_en;
    logic [IDX_W-1:0]         g_idx;
    logic [N_OF_INPUTS-1:0]   grant_c;

    // Increment an index, wrapping N-1 to 0 so the pointer never reaches N.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
        if (x == LAST)
            return '0;
        else
            return x + 1'b1;
    endfunction

    // In fixed mode, the scan always starts at index 0.
    assign scan_base = (RR_MODE != 0) ? rr_ptr : '0;

    // Rotate the requests so that the scan start sits at bit 0.
    always_comb begin
        req_rot = '0;
        for (int i = 0; i < N_OF_INPUTS; i++) begin
            for (int s = 0; s < N_OF_INPUTS; s++) begin
                if (scan_base == IDX_W'(s))
                    req_rot[i] = req_i[(i + s) % N_OF_INPUTS];
            end
        end
    end

    // Find the first set request at or after the scan start and map it back to
    // an absolute index, modulo N.
    always_comb begin
        win_any = |req_i;
        win_off = '0;
        for (int i = N_OF_INPUTS - 1; i >= 0; i--) begin
            if (req_rot[i])
                win_off = IDX_W'(i);
        end
        win_sum = {1'b0, scan_base} + {1'b0, win_off};
        if (win_sum >= N_EXT)
            win_sum = win_sum - N_EXT;
        win_idx = win_sum[IDX_W-1:0];
    end

    // Select the tail flag of the IDLE winner, and the request and tail flags of
    // the lock owner.
    always_comb begin
        win_tail = 1'b0;
        own_req  = 1'b0;
        own_tail = 1'b0;
        for (int i = 0; i < N_OF_INPUTS; i++) begin
            if (win_idx == IDX_W'(i))
                win_tail = tail_i[i];
            if (lock_idx == IDX_W'(i)) begin
                own_req  = req_i[i];
                own_tail = tail_i[i];
            end
        end
    end

    // Register the state, the lock owner and the RR pointer. Reset abandons any
    // packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nx;
            lock_idx <= lock_nx;
            rr_ptr   <= ptr_nx;
        end
    end

    // Compute the next state and the grant selection.
    // - IDLE: a head flit without a tail takes the lock.
    // - LOCKED: the tail flit releases the lock.
    always_comb begin
        state_nx = state;
        lock_nx  = lock_idx;
        ptr_nx   = rr_ptr;
        valid_o  = 1'b0;
        g_en     = 1'b0;
        g_idx    = '0;
        case (state)
            IDLE: begin
                g_en    = win_any;
                g_idx   = win_any ? win_idx : '0;
                valid_o = win_any;
                if (win_any && ready_i) begin
                    if (win_tail) begin
                        if (RR_MODE != 0)
                            ptr_nx = wrap_inc(win_idx);
                    end else begin
                        state_nx = LOCKED;
                        lock_nx  = win_idx;
                    end
                end
            end
            LOCKED: begin
                // Hold the grant on the owner even through bubbles.
                g_en    = 1'b1;
                g_idx   = lock_idx;
                valid_o = own_req;
                if (own_req && ready_i && own_tail) begin
                    state_nx = IDLE;
                    if (RR_MODE != 0)
                        ptr_nx = wrap_inc(lock_idx);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Decode the selected index into a one-hot grant.
    always_comb begin
        grant_c = '0;
        for (int i = 0; i < N_OF_INPUTS; i++)
            grant_c[i] = g_en && (g_idx == IDX_W'(i));
    end

    // With a single input, the grant simply mirrors the request.
    generate
        if (N_OF_INPUTS == 1) begin : g_single
            assign grant_o = req_i;
        end else begin : g_multi
            assign grant_o = grant_c;
        end
    endgenerate

    assign grant_idx_o = g_idx;
    assign locked_o    = (state == LOCKED);

endmodule
